// File: rtl/sram_bank_ctrl.sv
// Z80 SRAM bank controller: I/O-loaded bank config, 16K segment remap, SRAM strobes.
// Define WE_HOLD_EN to keep CE low for one clock after WE rises.
module sram_bank_ctrl #(
  parameter logic [2:0] BANK_MASK = 3'b111
) (
  input  logic        clk,
  input  logic        reset_b,
  input  logic [15:0] adr,
  input  logic [7:0]  data,
  input  logic        mreq_b,
  input  logic        iorq_b,
  input  logic        rd_b,
  input  logic        wr_b,
  input  logic        m1_b,
  output logic [4:0]  sram_adr,
  output logic        sram_ce_b,
  output logic        sram_oe_b,
  output logic        sram_we_b,
  output logic        ramdis
);

  typedef enum logic [2:0] {
    IDLE, READ, WSETUP, WRITE, WHOLD
  } state_t;

  state_t r_state, w_nstate;

  logic [4:0] r_s1, r_s2;
  logic [5:0] r_cfg;
  logic       r_io_arm;
  logic       r_ready;
  logic [4:0] r_sram_adr;
  logic       r_ce_b, r_oe_b, r_we_b;

  logic       w_mreq, w_iorq, w_rd, w_wr, w_m1;
  logic [2:0] w_bank, w_mode;
  logic [1:0] w_seg, w_blk;
  logic       w_hit, w_cfg_wr;
  logic       w_ce_b, w_oe_b, w_we_b;
  logic       w_unused_adr;

  assign w_unused_adr = ^adr[13:0];

  assign {w_m1, w_wr, w_rd, w_iorq, w_mreq} = r_s2;

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_s1 <= '1;
      r_s2 <= '1;
    end else begin
      r_s1 <= {m1_b, wr_b, rd_b, iorq_b, mreq_b};
      r_s2 <= r_s1;
    end
  end

  assign w_bank = r_cfg[5:3] & BANK_MASK;
  assign w_mode = r_cfg[2:0];
  assign w_seg  = adr[15:14];

  always_comb begin
    w_hit = 1'b0;
    w_blk = w_seg;
    case (w_mode)
      3'd1, 3'd3: begin
        w_hit = (w_seg == 2'd3);
        w_blk = 2'd3;
      end
      3'd2: w_hit = 1'b1;
      default: begin
        w_hit = w_mode[2] & (w_seg == 2'd1);
        w_blk = w_mode[1:0];
      end
    endcase
  end

  assign ramdis = ~mreq_b & w_hit;

  // One load per I/O cycle: disarm on load, rearm once IORQ is seen high.
  assign w_cfg_wr = r_io_arm & ~w_iorq & ~w_wr & w_m1 &
                    ~adr[15] & (data[7:6] == 2'b11);

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_cfg    <= 6'h00;
      r_io_arm <= 1'b1;
      r_ready  <= 1'b0;
    end else begin
      if (w_cfg_wr)
        r_cfg <= data[5:0];
      if (w_iorq)
        r_io_arm <= 1'b1;
      else if (w_cfg_wr)
        r_io_arm <= 1'b0;
      if (w_mreq & w_rd & w_wr)
        r_ready <= 1'b1;
    end
  end

  always_comb begin
    w_nstate = r_state;
    case (r_state)
      IDLE: begin
        if (r_ready & ~w_mreq & w_hit) begin
          if (!w_rd)
            w_nstate = READ;
          else if (!w_wr)
            w_nstate = WSETUP;
        end
      end
      READ:   if (w_rd | w_mreq) w_nstate = IDLE;
      WSETUP: w_nstate = WRITE;
`ifdef WE_HOLD_EN
      WRITE:  if (w_wr) w_nstate = WHOLD;
`else
      WRITE:  if (w_wr) w_nstate = IDLE;
`endif
      default: w_nstate = IDLE;
    endcase
  end

  always_comb begin
    w_ce_b = 1'b1;
    w_oe_b = 1'b1;
    w_we_b = 1'b1;
    case (w_nstate)
      READ: begin
        w_ce_b = 1'b0;
        w_oe_b = 1'b0;
      end
      WSETUP, WHOLD: w_ce_b = 1'b0;
      WRITE: begin
        w_ce_b = 1'b0;
        w_we_b = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_state    <= IDLE;
      r_sram_adr <= 5'h00;
      r_ce_b     <= 1'b1;
      r_oe_b     <= 1'b1;
      r_we_b     <= 1'b1;
    end else begin
      r_state <= w_nstate;
      r_ce_b  <= w_ce_b;
      r_oe_b  <= w_oe_b;
      r_we_b  <= w_we_b;
      if (r_state == IDLE && w_nstate != IDLE)
        r_sram_adr <= {w_bank, w_blk};
    end
  end

  assign sram_adr  = r_sram_adr;
  assign sram_ce_b = r_ce_b;
  assign sram_oe_b = r_oe_b;
  assign sram_we_b = r_we_b;

endmodule
